// File: rtl/arbiter_rr_ctrl_if.sv
// Request/grant bundle between requesters (master) and the round-robin
// controller (slave).
interface arbiter_rr_ctrl_if #(
    parameter int REQ_WIDTH = 8,
    parameter int ID_WIDTH  = $clog2(REQ_WIDTH)
);
    logic [REQ_WIDTH-1:0] req;
    logic [REQ_WIDTH-1:0] done;
    logic [REQ_WIDTH-1:0] gnt;
    logic [ID_WIDTH-1:0]  gnt_id;
    logic                 gnt_valid;
    logic                 preempt;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_valid, preempt
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_valid, preempt
    );
endinterface

// File: rtl/arbiter_rr_ctrl.sv
// Round-robin tenure arbiter: holds a one-hot grant until done, abandon or
// MAX_HOLD timeout, then rotates priority past the released owner.
module arbiter_rr_ctrl #(
    parameter int REQ_WIDTH = 8,
    parameter int ID_WIDTH  = $clog2(REQ_WIDTH),
    parameter int MAX_HOLD  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    arbiter_rr_ctrl_if.slave   bus
);
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) + 1 : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_reg, state_next;
    logic [REQ_WIDTH-1:0] gnt_reg, gnt_next;
    logic [REQ_WIDTH-1:0] base_reg, base_next;
    logic [ID_WIDTH-1:0]  gnt_id_reg, gnt_id_next;
    logic                 gnt_valid_reg, gnt_valid_next;
    logic                 preempt_reg, preempt_next;
    logic [CNT_W-1:0]     hold_cnt_reg, hold_cnt_next;

    logic                 owner_done;
    logic                 owner_gone;
    logic                 timeout;
    logic [REQ_WIDTH-1:0] base_rot;
    logic [ID_WIDTH-1:0]  id_term [REQ_WIDTH];

    // First set bit of r at or above the one-hot base b, wrapping MSB->LSB.
    function automatic logic [REQ_WIDTH-1:0] pick(input logic [REQ_WIDTH-1:0] r,
                                                  input logic [REQ_WIDTH-1:0] b);
        logic [2*REQ_WIDTH-1:0] r2;
        logic [2*REQ_WIDTH-1:0] g2;
        r2 = {r, r};
        g2 = r2 & ~(r2 - {{REQ_WIDTH{1'b0}}, b});
        return g2[2*REQ_WIDTH-1:REQ_WIDTH] | g2[REQ_WIDTH-1:0];
    endfunction

    assign owner_done = |(bus.done & gnt_reg);
    assign owner_gone = ~|(bus.req & gnt_reg);
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
    assign base_rot   = {gnt_reg[REQ_WIDTH-2:0], gnt_reg[REQ_WIDTH-1]};

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        base_next     = base_reg;
        hold_cnt_next = hold_cnt_reg;
        preempt_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    gnt_next      = pick(bus.req, base_reg);
                    hold_cnt_next = '0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (owner_done || owner_gone || timeout) begin
                    base_next     = base_rot;
                    gnt_next      = pick(bus.req, base_rot);
                    hold_cnt_next = '0;
                    preempt_next  = timeout && !owner_done && !owner_gone;
                    if (gnt_next == '0) begin
                        state_next = IDLE;
                    end
                end else if (hold_cnt_reg != '1) begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One-hot to binary: OR of per-bit index terms.
    generate
        for (genvar gi = 0; gi < REQ_WIDTH; gi++) begin : g_id_term
            assign id_term[gi] = gnt_next[gi] ? ID_WIDTH'(gi) : '0;
        end
    endgenerate

    always_comb begin
        gnt_id_next = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            gnt_id_next = gnt_id_next | id_term[i];
        end
        gnt_valid_next = |gnt_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            base_reg      <= {{(REQ_WIDTH-1){1'b0}}, 1'b1};
            gnt_id_reg    <= '0;
            gnt_valid_reg <= 1'b0;
            preempt_reg   <= 1'b0;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            base_reg      <= base_next;
            gnt_id_reg    <= gnt_id_next;
            gnt_valid_reg <= gnt_valid_next;
            preempt_reg   <= preempt_next;
            hold_cnt_reg  <= hold_cnt_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_id    = gnt_id_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.preempt   = preempt_reg;
endmodule
